sram_port_arbiter: RTL and testbench

- Shares one SRAM wrapper port (either port a or port b) among NUM_REQ requesters, e.g. core data bus, DMA and config loader.
- Uses round-robin arbitration with valid/ready handshakes. A conf_mode input locks the port to the config requester.
- Drives the SRAM command combinationally from the winning requester.
- Routes each read response back to its issuer exactly RD_LAT cycles after acceptance, using an internal tag pipeline.

---
 rtl/mem_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/sram_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
package mem_arb_pkg;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = 3;

    // Command presented to the SRAM wrapper port.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } sram_cmd_t;

    // One stage of the read-response tag pipeline.
    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } rd_tag_t;

    // True when a tag stage carries a live read issued by requester idx.
    function automatic logic tag_hits(input rd_tag_t tag, input int unsigned idx);
        logic [31:0] idx_v;
        idx_v = idx;
        return tag.valid && (tag.id == idx_v[ID_W-1:0]);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;

    // Scan requesters starting at the pointer; the first eligible one wins.
    always_comb begin
        grant       = {NUM_REQ{1'b0}};
        grant_idx   = {IDX_W{1'b0}};
        grant_valid = 1'b0;
        sum_s       = {(IDX_W+1){1'b0}};
        cand_s      = {IDX_W{1'b0}};
        for (int off = 0; off < NUM_REQ; off++) begin
            sum_s = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (sum_s >= (IDX_W+1)'(NUM_REQ)) begin
                sum_s = sum_s - (IDX_W+1)'(NUM_REQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[IDX_W-1:0];
            if (!grant_valid && eligible[cand_s]) begin
                grant_valid    = 1'b1;
                grant[cand_s]  = 1'b1;
                grant_idx      = cand_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port among NUM_REQ requesters with round-robin arbitration,
// an exclusive config-mode lock, and in-order read responses after RD_LAT cycles.
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int RD_LAT  = 1,
    parameter int CONF_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  conf_mode,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]  req_wstrb,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  sram_we,
    output logic                  sram_rd,
    output logic [31:0]           sram_addr,
    output logic [31:0]           sram_din,
    output logic [3:0]            sram_strb,
    input  logic [31:0]           sram_dout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] mask_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               grant_valid_s;
    logic [IDX_W-1:0]   rr_ptr_r;
    logic [IDX_W-1:0]   ptr_next_s;
    logic               accept_rd_s;
    sram_cmd_t          cmd_s;
    rd_tag_t            tag_r [RD_LAT];

    // Eligible set: config mode narrows the field to CONF_ID; reset blocks everyone.
    always_comb begin
        mask_s = {NUM_REQ{1'b1}};
        if (conf_mode) begin
            mask_s          = {NUM_REQ{1'b0}};
            mask_s[CONF_ID] = 1'b1;
        end else begin
            mask_s = {NUM_REQ{1'b1}};
        end
        if (rst_n) begin
            eligible_s = req_valid & mask_s;
        end else begin
            eligible_s = {NUM_REQ{1'b0}};
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .eligible    (eligible_s),
        .rr_ptr      (rr_ptr_r),
        .grant       (grant_s),
        .grant_idx   (grant_idx_s),
        .grant_valid (grant_valid_s)
    );

    // Grant only ever lands on a valid requester, so ready equals grant.
    always_comb begin
        req_ready = grant_s;
    end

    // Mux the winning requester's fields onto the SRAM command.
    always_comb begin
        cmd_s = {1'b0, 32'd0, 32'd0, 4'd0};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                cmd_s.we    = req_we[i];
                cmd_s.addr  = req_addr[i*32 +: 32];
                cmd_s.wdata = req_wdata[i*32 +: 32];
                cmd_s.wstrb = req_wstrb[i*4 +: 4];
            end else begin
                cmd_s = cmd_s;
            end
        end
        sram_we     = cmd_s.we & grant_valid_s;
        sram_rd     = ~cmd_s.we & grant_valid_s;
        sram_addr   = cmd_s.addr;
        sram_din    = cmd_s.wdata;
        sram_strb   = cmd_s.wstrb;
        accept_rd_s = grant_valid_s & ~cmd_s.we;
        if (grant_idx_s == IDX_W'(NUM_REQ - 1)) begin
            ptr_next_s = {IDX_W{1'b0}};
        end else begin
            ptr_next_s = grant_idx_s + IDX_W'(1);
        end
    end

    // Advance the pointer past the winner; config mode freezes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (grant_valid_s && !conf_mode) begin
            rr_ptr_r <= ptr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Read tag shift register: one stage per cycle of SRAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_r[i] <= {1'b0, 3'd0};
            end
        end else begin
            if (accept_rd_s) begin
                tag_r[0] <= {1'b1, ID_W'(grant_idx_s)};
            end else begin
                tag_r[0] <= {1'b0, 3'd0};
            end
            for (int i = 1; i < RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Final tag stage steers the returning SRAM data to its issuer.
    always_comb begin
        resp_valid = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_hits(tag_r[RD_LAT-1], i);
        end
        if (tag_r[RD_LAT-1].valid) begin
            resp_rdata = sram_dout;
        end else begin
            resp_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Table-driven bench for sram_port_arbiter with a behavioural SRAM and a
// response scoreboard.
module tb_sram_port_arbiter;

    localparam int NUM_REQ = 2;
    localparam int RD_LAT  = 2;
    localparam int CONF_ID = 0;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  conf_mode;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_we;
    logic [NUM_REQ*32-1:0] req_addr;
    logic [NUM_REQ*32-1:0] req_wdata;
    logic [NUM_REQ*4-1:0]  req_wstrb;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [31:0]           resp_rdata;
    logic                  sram_we;
    logic                  sram_rd;
    logic [31:0]           sram_addr;
    logic [31:0]           sram_din;
    logic [3:0]            sram_strb;
    logic [31:0]           sram_dout;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .RD_LAT  (RD_LAT),
        .CONF_ID (CONF_ID)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conf_mode  (conf_mode),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .sram_we    (sram_we),
        .sram_rd    (sram_rd),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_strb  (sram_strb),
        .sram_dout  (sram_dout)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'hA5A5_0010;
        if (i == 32) return 32'h5A5A_0020;
        if (i == 4)  return 32'h1122_3344;
        return 32'hC0DE_0000 | i;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural SRAM: byte-strobed writes, RD_LAT-cycle read pipeline.
    logic        load_en;
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= 32'd0;
        end else begin
            if (sram_we) mem[sram_addr[7:0]] <= merge(mem[sram_addr[7:0]], sram_din, sram_strb);
            rd_pipe[0] <= mem[sram_addr[7:0]];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign sram_dout = rd_pipe[RD_LAT-1];

    // Requester protocol: fields stay put while valid and not yet ready.
    logic [NUM_REQ-1:0] pv, pr;
    logic               prst = 1'b0;
    logic [68:0]        pf [NUM_REQ];
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prst && rst_n && pv[i] && !pr[i])
                assert (req_valid[i] && {req_we[i], req_addr[i*32 +: 32], req_wdata[i*32 +: 32],
                        req_wstrb[i*4 +: 4]} == pf[i])
                else $error("FAIL protocol: requester %0d changed fields before ready", i);
            pf[i] <= {req_we[i], req_addr[i*32 +: 32], req_wdata[i*32 +: 32], req_wstrb[i*4 +: 4]};
        end
        pv   <= req_valid;
        pr   <= req_ready;
        prst <= rst_n;
    end

    typedef struct {
        logic        conf;
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [31:0] a0, a1, d0, d1;
        logic [3:0]  s0, s1;
        logic [1:0]  exp_ready;
    } vec_t;

    typedef struct {
        int          due;
        logic [1:0]  id_oh;
        logic [31:0] data;
    } resp_t;

    vec_t        vecs[$];
    resp_t       sb[$];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;

    function automatic vec_t mk(input logic conf, input logic [1:0] valid, input logic [1:0] we,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [3:0] s0, input logic [3:0] s1,
                                input logic [1:0] exp_ready);
        vec_t v;
        v.conf = conf; v.valid = valid; v.we = we; v.a0 = a0; v.a1 = a1;
        v.d0 = d0; v.d1 = d1; v.s0 = s0; v.s1 = s1; v.exp_ready = exp_ready;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 2'b00);
    endfunction

    function automatic vec_t rd(input logic conf, input logic [1:0] valid, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [1:0] exp_ready);
        return mk(conf, valid, 2'b00, a0, a1, 32'd0, 32'd0, 4'd0, 4'd0, exp_ready);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        else passed++;
    endtask

    task automatic check_resp();
        resp_t r;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            check("resp_valid", 128'(resp_valid), 128'(r.id_oh));
            check("resp_rdata", 128'(resp_rdata), 128'(r.data));
        end else begin
            check("resp_valid_idle", 128'(resp_valid), 128'd0);
        end
    endtask

    task automatic apply(input vec_t v);
        logic [69:0] exp_cmd;
        int          w;
        logic [31:0] wa, wd;
        logic [3:0]  ws;
        logic        wwe;
        @(negedge clk);
        rst_n     = 1'b1;
        conf_mode = v.conf;
        req_valid = v.valid;
        req_we    = v.we;
        req_addr  = {v.a1, v.a0};
        req_wdata = {v.d1, v.d0};
        req_wstrb = {v.s1, v.s0};
        #1;
        check("req_ready", 128'(req_ready), 128'(v.exp_ready));
        w   = v.exp_ready[1] ? 1 : 0;
        wa  = (w == 1) ? v.a1 : v.a0;
        wd  = (w == 1) ? v.d1 : v.d0;
        ws  = (w == 1) ? v.s1 : v.s0;
        wwe = v.we[w];
        if (v.exp_ready != 2'b00) exp_cmd = {wwe, ~wwe, wa, wd, ws};
        else exp_cmd = 70'd0;
        check("sram_cmd", 128'({sram_we, sram_rd, sram_addr, sram_din, sram_strb}), 128'(exp_cmd));
        check_resp();
        if (v.exp_ready != 2'b00) begin
            if (wwe) ref_mem[wa[7:0]] = merge(ref_mem[wa[7:0]], wd, ws);
            else sb.push_back('{due: cyc + RD_LAT, id_oh: v.exp_ready, data: ref_mem[wa[7:0]]});
        end
        cyc++;
    endtask

    task automatic do_reset(input int n, input logic [1:0] valid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n     = 1'b0;
            req_valid = valid;
            #1;
            check("reset_ready", 128'(req_ready), 128'd0);
            check("reset_cmd", 128'({sram_we, sram_rd, sram_addr, sram_din, sram_strb}), 128'd0);
            if (i > 0) begin
                check("reset_resp_valid", 128'(resp_valid), 128'd0);
                check("reset_resp_rdata", 128'(resp_rdata), 128'd0);
            end
            cyc++;
        end
        sb.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        load_en   = 1'b1;
        conf_mode = 1'b0;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {32'h20, 32'h10};
        req_wdata = 64'd0;
        req_wstrb = 8'd0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Round-robin alternation, both reading.
        vecs.push_back(rd(1'b0, 2'b11, 32'h10, 32'h20, 2'b01));
        vecs.push_back(rd(1'b0, 2'b11, 32'h10, 32'h20, 2'b10));
        vecs.push_back(rd(1'b0, 2'b11, 32'h10, 32'h20, 2'b01));
        vecs.push_back(rd(1'b0, 2'b10, 32'h10, 32'h20, 2'b10));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Byte-strobed write then read-back by requester 1.
        vecs.push_back(mk(1'b0, 2'b10, 2'b10, 32'd0, 32'h4, 32'd0, 32'hDEAD_BEEF, 4'd0, 4'b0101, 2'b10));
        vecs.push_back(rd(1'b0, 2'b10, 32'd0, 32'h4, 2'b10));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Zero-strobe write still issues sram_we, data unchanged.
        vecs.push_back(mk(1'b0, 2'b01, 2'b01, 32'h5, 32'd0, 32'hFFFF_FFFF, 32'd0, 4'b0000, 4'd0, 2'b01));
        vecs.push_back(rd(1'b0, 2'b01, 32'h5, 32'd0, 2'b01));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Pointer sits at 1 after requester 0 won.
        vecs.push_back(rd(1'b0, 2'b11, 32'h10, 32'h20, 2'b10));
        vecs.push_back(rd(1'b0, 2'b01, 32'h10, 32'h20, 2'b01));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Config lock: requester 1 starved, then granted as soon as the lock drops.
        for (int i = 0; i < 10; i++) vecs.push_back(rd(1'b1, 2'b10, 32'd0, 32'h20, 2'b00));
        vecs.push_back(rd(1'b1, 2'b11, 32'h10, 32'h20, 2'b01));
        vecs.push_back(rd(1'b0, 2'b10, 32'd0, 32'h20, 2'b10));
        // Read in flight across a lock toggle; pointer frozen while locked.
        vecs.push_back(rd(1'b0, 2'b10, 32'd0, 32'h20, 2'b10));
        vecs.push_back(rd(1'b1, 2'b01, 32'h10, 32'd0, 2'b01));
        vecs.push_back(rd(1'b0, 2'b11, 32'h10, 32'h20, 2'b01));
        vecs.push_back(rd(1'b0, 2'b10, 32'h10, 32'h20, 2'b10));
        vecs.push_back(idle()); vecs.push_back(idle());
        // Back-to-back reads from requester 0.
        for (int i = 0; i < 8; i++) vecs.push_back(rd(1'b0, 2'b01, 32'(i), 32'd0, 2'b01));
        vecs.push_back(idle()); vecs.push_back(idle());

        do_reset(3, 2'b11);
        load_en = 1'b0;
        foreach (vecs[k]) apply(vecs[k]);

        // Reset one cycle after a read is accepted: the response must vanish.
        apply(rd(1'b0, 2'b01, 32'h10, 32'd0, 2'b01));
        do_reset(2, 2'b00);
        for (int i = 0; i < 5; i++) apply(idle());

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
